dsp_m_share_sched: RTL and testbench
====================================

// Module: dsp_m_share_sched
// PURPOSE
//  Round-robin scheduler sharing one DSP multiplier-output (M) register stage between NREQ requesters.
//  Each requester offers a partial-product pair (U,V) with a valid/ready handshake. The block grants one
//  requester per cycle, drives the M-stage clock enable, and tags each output beat with the granted index.
//  It sits between the multiplier front-ends and the post-adder/ALU input of the DSP slice.
// PARAMETERS
//  NREQ   4   number of requesters, 2..8
//  IDW    2   tag width, $clog2(NREQ)
//  MREG   1   1 = registered M stage; 0 = combinational bypass (grant is still arbitrated)
// PORTS
//  CLK_mreg    in   1          stage clock, rising edge
//  RSTM        in   1          reset, asynchronous, active-low
//  flush       in   1          synchronous drop of the held beat
//  req_valid   in   NREQ       per-requester offer valid
//  req_ready   out  NREQ       per-requester accept, one-hot or zero
//  req_u       in   NREQ*45    packed U operands; requester i occupies [45*i +: 45]
//  req_v       in   NREQ*45    packed V operands; same packing as req_u
//  out_valid   out  1          U_DATA/V_DATA/out_id hold a valid beat
//  out_ready   in   1          downstream accept
//  U_DATA      out  45         M-stage U output
//  V_DATA      out  45         M-stage V output
//  out_id      out  IDW        index of the requester that owns the beat
//  CEM         out  1          M-stage clock enable (load strobe)
//  grant_cnt   out  16         wrapping count of accepted beats
// BEHAVIOUR
//  - Reset (RSTM=0, async) values: out_valid=0; U_DATA=V_DATA=45'h100000000000 (null product);
//    out_id=0; rr_ptr=0; grant_cnt=0; state=RUN; req_ready=0 while in reset.
//  - Register enable: CEM = flush | ~out_valid | out_ready. Load occurs only on CEM.
//  - Arbitration: among req_valid bits, pick the first set bit at or after rr_ptr (cyclic order).
//    req_ready[g]=1 only if CEM=1 and state!=FLUSH.
//  - Accept: a beat is accepted when req_valid[g] & req_ready[g]. On accept, rr_ptr <= (g+1) mod NREQ.
//    With no accept, rr_ptr holds. Requester i is therefore granted within NREQ accepts.
//  - MREG=1: latency is 1 cycle. On accept, U_DATA/V_DATA/out_id load the granted operands and tag,
//    and out_valid<=1. If CEM=1 with no accept, out_valid<=0 and the data holds its value.
//  - MREG=0: U_DATA/V_DATA/out_id/out_valid are driven combinationally from the current grant.
//    out_valid = |req_valid. req_ready[g] = out_ready. flush has no effect; state stays RUN.
//  - FSM (MREG=1):
//    RUN -> HOLD   when out_valid and ~out_ready.
//    HOLD -> RUN   when out_ready.
//    any -> FLUSH  when flush=1.
//    FLUSH -> RUN  after 1 cycle.
//  - FLUSH cycle: out_valid<=0; U_DATA/V_DATA<=45'h100000000000; no grant issued;
//    rr_ptr and grant_cnt hold.
//  - Simultaneous flush and out_ready: flush wins and the beat is dropped (not counted as accepted).
//  - Simultaneous out_ready and new accept in RUN: pass-through with no bubble, full throughput.
//  - grant_cnt increments on each accept and wraps 16'hFFFF -> 0.
//  - A mid-operation RSTM assertion discards the held beat immediately (async); no partial state is retained.
//  - Operand values are passed through untouched; no arithmetic is applied to them.
// STRUCTURE
//  - Shared package dsp_m_pkg: NULL_PROD=45'h100000000000, M_W=45, state enum {RUN,HOLD,FLUSH}.
//  - One sub-module rr_arbiter_nreq (NREQ, rotating priority, one-hot grant + encoded index).
//  - The top level holds the FSM, CEM logic, the U/V/id register and grant_cnt.
// TESTING
//  1. Reset: RSTM=0 mid-beat -> out_valid=0, U_DATA=45'h100000000000, grant_cnt=0 without a clock edge.
//  2. All 4 requesters valid, out_ready=1 -> out_id sequence 0,1,2,3,0 on consecutive cycles; grant_cnt=5.
//  3. Backpressure: beat from req 2 (U=45'h1234) held while out_ready=0 for 3 cycles -> U_DATA is stable,
//     CEM=0, req_ready=0; released on the cycle out_ready=1.
//  4. flush while holding the req 1 beat with out_ready=1 -> next cycle out_valid=0, U_DATA=NULL_PROD,
//     grant_cnt unchanged, rr_ptr unchanged.
//  5. Only req 3 valid, rr_ptr=0 -> granted immediately; rr_ptr becomes 0 (wrap).
//  6. grant_cnt preset near 16'hFFFF via 65535 accepts -> next accept reads 0.

Source files
------------

// File: rtl/dsp_m_pkg.sv
// Shared definitions for the DSP M-stage sharing logic: operand width,
// the null product value and the scheduler state encoding.
package dsp_m_pkg;

  localparam int M_W = 45;
  localparam logic [M_W-1:0] NULL_PROD = 45'h100000000000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter_nreq.sv
// Rotating-priority arbiter: grants the first valid requester at or after
// the pointer in cyclic order, as a one-hot vector plus an encoded index.
module rr_arbiter_nreq #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  logic [IDW-1:0] cand;

  // Scan from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(ptr_i) + k) % NREQ);
      if (valid_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dsp_m_share_sched.sv
// Round-robin scheduler sharing one DSP M register stage between NREQ
// requesters; tags each output beat with the owning requester index.
module dsp_m_share_sched
  import dsp_m_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ),
  parameter int MREG = 1
) (
  input  logic                CLK_mreg,
  input  logic                RSTM,
  input  logic                flush,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*M_W-1:0] req_u,
  input  logic [NREQ*M_W-1:0] req_v,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [M_W-1:0]      U_DATA,
  output logic [M_W-1:0]      V_DATA,
  output logic [IDW-1:0]      out_id,
  output logic                CEM,
  output logic [15:0]         grant_cnt
);

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic            ready_en;
  logic            load_en;
  logic            accept;
  logic [M_W-1:0]  sel_u;
  logic [M_W-1:0]  sel_v;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [15:0]     grant_cnt_q, grant_cnt_d;

  rr_arbiter_nreq #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any)
  );

  always_comb begin
    sel_u = NULL_PROD;
    sel_v = NULL_PROD;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_u = req_u[i*M_W +: M_W];
        sel_v = req_v[i*M_W +: M_W];
      end
    end
  end

  assign req_ready = gnt & {NREQ{ready_en}};
  assign accept    = gnt_any & ready_en;
  assign CEM       = load_en;
  assign grant_cnt = grant_cnt_q;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    grant_cnt_d = grant_cnt_q;
    if (accept) begin
      rr_ptr_d    = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
      grant_cnt_d = grant_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK_mreg or negedge RSTM) begin
    if (!RSTM) begin
      rr_ptr_q    <= '0;
      grant_cnt_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  if (MREG != 0) begin : g_mreg
    state_e         state_q;
    logic           out_valid_q;
    logic [M_W-1:0] u_q, v_q;
    logic [IDW-1:0] id_q;

    assign load_en   = flush | ~out_valid_q | out_ready;
    assign ready_en  = RSTM & load_en & ~flush & (state_q != FLUSH);
    assign out_valid = out_valid_q;
    assign U_DATA    = u_q;
    assign V_DATA    = v_q;
    assign out_id    = id_q;

    // A flush request and the FLUSH state both drop the beat; the FLUSH
    // state additionally blocks one grant so the pipe stays empty a cycle.
    always_ff @(posedge CLK_mreg or negedge RSTM) begin
      if (!RSTM) begin
        state_q     <= RUN;
        out_valid_q <= 1'b0;
        u_q         <= NULL_PROD;
        v_q         <= NULL_PROD;
        id_q        <= '0;
      end else if (flush || state_q == FLUSH) begin
        state_q     <= flush ? FLUSH : RUN;
        out_valid_q <= 1'b0;
        u_q         <= NULL_PROD;
        v_q         <= NULL_PROD;
      end else begin
        case (state_q)
          RUN:     if (out_valid_q && !out_ready) state_q <= HOLD;
          HOLD:    if (out_ready) state_q <= RUN;
          default: state_q <= RUN;
        endcase
        if (accept) begin
          out_valid_q <= 1'b1;
          u_q         <= sel_u;
          v_q         <= sel_v;
          id_q        <= gnt_idx;
        end else if (load_en) begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end else begin : g_bypass
    assign out_valid = RSTM & gnt_any;
    assign load_en   = flush | ~out_valid | out_ready;
    assign ready_en  = RSTM & out_ready;
    assign U_DATA    = sel_u;
    assign V_DATA    = sel_v;
    assign out_id    = gnt_idx;
  end

endmodule

// File: tb/tb_dsp_m_share_sched.sv
// Self-checking bench for dsp_m_share_sched (NREQ=4, MREG=1): a
// behavioural model checked every cycle plus directed literal checks.
module tb_dsp_m_share_sched;

  localparam logic [44:0] NULL_V = 45'h100000000000;

  logic         CLK_mreg;
  logic         RSTM;
  logic         flush;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [179:0] req_u;
  logic [179:0] req_v;
  logic         out_valid;
  logic         out_ready;
  logic [44:0]  U_DATA;
  logic [44:0]  V_DATA;
  logic [1:0]   out_id;
  logic         CEM;
  logic [15:0]  grant_cnt;

  logic [44:0] uOp[4];
  logic [44:0] vOp[4];
  assign req_u = {uOp[3], uOp[2], uOp[1], uOp[0]};
  assign req_v = {vOp[3], vOp[2], vOp[1], vOp[0]};

  int testsRun    = 0;
  int testsFailed = 0;
  logic chkEn = 1'b0;

  dsp_m_share_sched #(.NREQ(4), .IDW(2), .MREG(1)) dut (
    .CLK_mreg  (CLK_mreg),
    .RSTM      (RSTM),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_u     (req_u),
    .req_v     (req_v),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .U_DATA    (U_DATA),
    .V_DATA    (V_DATA),
    .out_id    (out_id),
    .CEM       (CEM),
    .grant_cnt (grant_cnt)
  );

  initial begin
    CLK_mreg = 1'b0;
    forever #5 CLK_mreg = ~CLK_mreg;
  end

  // Behavioural model state: the held beat, pointer, count, flush shadow.
  logic        mValid;
  logic [44:0] mU, mV;
  logic [1:0]  mId, mPtr;
  logic [15:0] mCnt;
  logic        mFlushing;

  function automatic logic [1:0] pickIdx();
    logic [1:0] res, j;
    res = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      j = mPtr + 2'(k);
      if (req_valid[j]) res = j;
    end
    return res;
  endfunction

  function automatic logic modelCem();
    return flush | ~mValid | out_ready;
  endfunction

  function automatic logic [3:0] modelReady();
    if (RSTM && modelCem() && !flush && !mFlushing && (|req_valid))
      return 4'b0001 << pickIdx();
    return 4'b0000;
  endfunction

  always @(posedge CLK_mreg or negedge RSTM) begin
    if (!RSTM) begin
      mValid <= 1'b0; mU <= NULL_V; mV <= NULL_V; mId <= 2'd0;
      mPtr <= 2'd0; mCnt <= 16'd0; mFlushing <= 1'b0;
    end else begin
      mFlushing <= flush;
      if (flush || mFlushing) begin
        mValid <= 1'b0; mU <= NULL_V; mV <= NULL_V;
      end else if (|modelReady()) begin
        mValid <= 1'b1;
        mU     <= uOp[pickIdx()];
        mV     <= vOp[pickIdx()];
        mId    <= pickIdx();
        mPtr   <= pickIdx() + 2'd1;
        mCnt   <= mCnt + 16'd1;
      end else if (modelCem()) begin
        mValid <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK_mreg) begin
    if (chkEn) begin
      checkOutput("out_valid", 64'(out_valid), 64'(mValid));
      checkOutput("CEM", 64'(CEM), 64'(modelCem()));
      checkOutput("req_ready", 64'(req_ready), 64'(modelReady()));
      checkOutput("grant_cnt", 64'(grant_cnt), 64'(mCnt));
      checkOutput("U_DATA", 64'(U_DATA), 64'(mU));
      checkOutput("V_DATA", 64'(V_DATA), 64'(mV));
      if (mValid) checkOutput("out_id", 64'(out_id), 64'(mId));
    end
  end

  task automatic applyStimulus(input logic [3:0] v, input logic rdy, input logic fl);
    req_valid = v;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic stepCycle();
    @(posedge CLK_mreg);
    #1;
  endtask

  task automatic pulseReset();
    RSTM = 1'b0;
    stepCycle();
    stepCycle();
    RSTM = 1'b1;
  endtask

  logic [1:0] expIds[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    RSTM = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      uOp[i] = 45'(100 + i);
      vOp[i] = 45'(200 + i);
    end
    #1 RSTM = 1'b0;
    #12;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_U_DATA", 64'(U_DATA), 64'(NULL_V));
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    stepCycle();
    RSTM  = 1'b1;
    chkEn = 1'b1;

    // Mid-beat asynchronous reset
    applyStimulus(4'b1111, 1'b0, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("t1_pre_valid", 64'(out_valid), 64'd1);
    #1 RSTM = 1'b0;
    #1;
    checkOutput("t1_out_valid", 64'(out_valid), 64'd0);
    checkOutput("t1_U_DATA", 64'(U_DATA), 64'(NULL_V));
    checkOutput("t1_grant_cnt", 64'(grant_cnt), 64'd0);
    stepCycle();
    stepCycle();
    RSTM = 1'b1;

    // Full round-robin rotation
    applyStimulus(4'b1111, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      stepCycle();
      checkOutput("t2_out_id", 64'(out_id), 64'(expIds[k]));
    end
    checkOutput("t2_grant_cnt", 64'(grant_cnt), 64'd5);

    // Backpressure on a beat from requester 2
    uOp[2] = 45'h1234;
    applyStimulus(4'b0100, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(4'b1111, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #2;
      checkOutput("t3_U_DATA", 64'(U_DATA), 64'h1234);
      checkOutput("t3_out_id", 64'(out_id), 64'd2);
      checkOutput("t3_CEM", 64'(CEM), 64'd0);
      checkOutput("t3_req_ready", 64'(req_ready), 64'd0);
      stepCycle();
    end
    applyStimulus(4'b0000, 1'b1, 1'b0);
    #2 checkOutput("t3_release_CEM", 64'(CEM), 64'd1);
    stepCycle();
    checkOutput("t3_after_valid", 64'(out_valid), 64'd0);

    // Flush while holding the requester 1 beat
    applyStimulus(4'b0010, 1'b0, 1'b0);
    stepCycle();
    checkOutput("t4_held_id", 64'(out_id), 64'd1);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(4'b1111, 1'b1, 1'b1);
    #2 checkOutput("t4_flush_ready", 64'(req_ready), 64'd0);
    stepCycle();
    checkOutput("t4_out_valid", 64'(out_valid), 64'd0);
    checkOutput("t4_U_DATA", 64'(U_DATA), 64'(NULL_V));
    checkOutput("t4_grant_cnt", 64'(grant_cnt), 64'd7);
    applyStimulus(4'b1111, 1'b1, 1'b0);
    #2 checkOutput("t4_flushstate_ready", 64'(req_ready), 64'd0);
    stepCycle();
    #2 checkOutput("t4_ptr_ready", 64'(req_ready), 64'b0100);
    stepCycle();
    checkOutput("t4_next_id", 64'(out_id), 64'd2);

    // Lone requester 3 with pointer at 0, then wrap
    applyStimulus(4'b1000, 1'b1, 1'b0);
    stepCycle();
    #2 checkOutput("t5_ready", 64'(req_ready), 64'b1000);
    stepCycle();
    checkOutput("t5_out_id", 64'(out_id), 64'd3);
    applyStimulus(4'b1111, 1'b1, 1'b0);
    #2 checkOutput("t5_wrap_ready", 64'(req_ready), 64'b0001);
    stepCycle();
    checkOutput("t5_wrap_id", 64'(out_id), 64'd0);

    // Grant counter wrap
    pulseReset();
    applyStimulus(4'b1111, 1'b1, 1'b0);
    repeat (65535) stepCycle();
    checkOutput("t6_cnt_ffff", 64'(grant_cnt), 64'hFFFF);
    stepCycle();
    checkOutput("t6_cnt_wrap", 64'(grant_cnt), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          uOp[i] = 45'({$urandom(), $urandom()});
          vOp[i] = 45'({$urandom(), $urandom()});
        end
      end
      applyStimulus(4'($urandom()), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      stepCycle();
    end

    chkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
